// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI4 arbiter.
// States of the read and write path FSMs plus master count.
package axi_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle (addr/data 32, id 4, len 8) with arbiter-side modports.
// in: arbiter acts as slave; out: arbiter acts as master.
interface axi_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 4
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;

  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [IW-1:0] rid;

  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [IW-1:0] awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;

  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;

  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic [IW-1:0] bid;

  modport in (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

  modport out (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );
endinterface

// File: rtl/axi_arb_pick.sv
// Two-way request picker: fixed priority, or round-robin tie
// break on the last winner when AXI_ARB_RR_EN is defined.
module axi_arb_pick
  import axi_arb_pkg::*;
#(
  parameter int PRIO_MASTER = 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   last_i,
  output logic                   idx_o,
  output logic                   valid_o
);

  logic tie;

`ifdef AXI_ARB_RR_EN
  assign tie = ~last_i;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign tie = (PRIO_MASTER != 0);
`endif

  always_comb begin
    valid_o = |req_i;
    idx_o   = 1'b0;
    unique case (1'b1)
      (req_i == 2'b11): idx_o = tie;
      (req_i == 2'b10): idx_o = 1'b1;
      default:          idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_arbiter.sv
// IFU/LSU to one-port AXI4 arbiter, independent read and write paths.
// AXI_ARB_RR_EN selects round-robin tie-breaking per path.
module axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter int PRIO_MASTER = 1
) (
  input logic clock,
  input logic reset,
  axi_if.in   in0,
  axi_if.in   in1,
  axi_if.out  out
);

  rd_state_t rstate_q, rstate_d;
  wr_state_t wstate_q, wstate_d;
  logic rgnt_q, rgnt_d;
  logic wgnt_q, wgnt_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic rpick_idx, rpick_v;
  logic wpick_idx, wpick_v;
  logic rlast_win, wlast_win;

  axi_arb_pick #(.PRIO_MASTER(PRIO_MASTER)) u_rpick (
    .req_i   ({in1.arvalid, in0.arvalid}),
    .last_i  (rlast_win),
    .idx_o   (rpick_idx),
    .valid_o (rpick_v)
  );

  axi_arb_pick #(.PRIO_MASTER(PRIO_MASTER)) u_wpick (
    .req_i   ({in1.awvalid, in0.awvalid}),
    .last_i  (wlast_win),
    .idx_o   (wpick_idx),
    .valid_o (wpick_v)
  );

`ifdef AXI_ARB_RR_EN
  logic rwin_q, wwin_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rwin_q <= 1'b0;
      wwin_q <= 1'b0;
    end else begin
      if (rstate_q == R_IDLE && rpick_v)
        rwin_q <= rpick_idx;
      if (wstate_q == W_IDLE && wpick_v)
        wwin_q <= wpick_idx;
    end
  end

  assign rlast_win = rwin_q;
  assign wlast_win = wwin_q;
`else
  assign rlast_win = 1'b0;
  assign wlast_win = 1'b0;
`endif

  // Payload muxes follow the grant; valids are gated by the FSMs.
  assign out.araddr  = rgnt_q ? in1.araddr  : in0.araddr;
  assign out.arid    = rgnt_q ? in1.arid    : in0.arid;
  assign out.arlen   = rgnt_q ? in1.arlen   : in0.arlen;
  assign out.arsize  = rgnt_q ? in1.arsize  : in0.arsize;
  assign out.arburst = rgnt_q ? in1.arburst : in0.arburst;

  assign out.awaddr  = wgnt_q ? in1.awaddr  : in0.awaddr;
  assign out.awid    = wgnt_q ? in1.awid    : in0.awid;
  assign out.awlen   = wgnt_q ? in1.awlen   : in0.awlen;
  assign out.awsize  = wgnt_q ? in1.awsize  : in0.awsize;
  assign out.awburst = wgnt_q ? in1.awburst : in0.awburst;
  assign out.wdata   = wgnt_q ? in1.wdata   : in0.wdata;
  assign out.wstrb   = wgnt_q ? in1.wstrb   : in0.wstrb;
  assign out.wlast   = wgnt_q ? in1.wlast   : in0.wlast;

  assign in0.rdata = out.rdata;
  assign in0.rresp = out.rresp;
  assign in0.rlast = out.rlast;
  assign in0.rid   = out.rid;
  assign in1.rdata = out.rdata;
  assign in1.rresp = out.rresp;
  assign in1.rlast = out.rlast;
  assign in1.rid   = out.rid;
  assign in0.bresp = out.bresp;
  assign in0.bid   = out.bid;
  assign in1.bresp = out.bresp;
  assign in1.bid   = out.bid;

  logic ar_v_sel, r_rdy_sel;
  logic aw_v_sel, w_v_sel, w_last_sel, b_rdy_sel;

  assign ar_v_sel   = rgnt_q ? in1.arvalid : in0.arvalid;
  assign r_rdy_sel  = rgnt_q ? in1.rready  : in0.rready;
  assign aw_v_sel   = wgnt_q ? in1.awvalid : in0.awvalid;
  assign w_v_sel    = wgnt_q ? in1.wvalid  : in0.wvalid;
  assign w_last_sel = wgnt_q ? in1.wlast   : in0.wlast;
  assign b_rdy_sel  = wgnt_q ? in1.bready  : in0.bready;

  always_comb begin
    rstate_d    = rstate_q;
    rgnt_d      = rgnt_q;
    out.arvalid = 1'b0;
    out.rready  = 1'b0;
    in0.arready = 1'b0;
    in1.arready = 1'b0;
    in0.rvalid  = 1'b0;
    in1.rvalid  = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (rpick_v) begin
          rgnt_d   = rpick_idx;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        out.arvalid = ar_v_sel;
        if (rgnt_q) in1.arready = out.arready;
        else        in0.arready = out.arready;
        if (ar_v_sel && out.arready)
          rstate_d = R_DATA;
      end
      R_DATA: begin
        out.rready = r_rdy_sel;
        if (rgnt_q) in1.rvalid = out.rvalid;
        else        in0.rvalid = out.rvalid;
        if (out.rvalid && r_rdy_sel && out.rlast)
          rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  logic aw_hs, w_hs_last;

  assign aw_hs     = !aw_done_q && aw_v_sel && out.awready;
  assign w_hs_last = !w_done_q && w_v_sel && out.wready && w_last_sel;

  always_comb begin
    wstate_d    = wstate_q;
    wgnt_d      = wgnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    out.awvalid = 1'b0;
    out.wvalid  = 1'b0;
    out.bready  = 1'b0;
    in0.awready = 1'b0;
    in1.awready = 1'b0;
    in0.wready  = 1'b0;
    in1.wready  = 1'b0;
    in0.bvalid  = 1'b0;
    in1.bvalid  = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (wpick_v) begin
          wgnt_d   = wpick_idx;
          wstate_d = W_XFER;
        end
      end
      W_XFER: begin
        out.awvalid = !aw_done_q && aw_v_sel;
        out.wvalid  = !w_done_q && w_v_sel;
        if (wgnt_q) begin
          in1.awready = !aw_done_q && out.awready;
          in1.wready  = !w_done_q && out.wready;
        end else begin
          in0.awready = !aw_done_q && out.awready;
          in0.wready  = !w_done_q && out.wready;
        end
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs_last;
        if (aw_done_d && w_done_d)
          wstate_d = W_RESP;
      end
      W_RESP: begin
        out.bready = b_rdy_sel;
        if (wgnt_q) in1.bvalid = out.bvalid;
        else        in0.bvalid = out.bvalid;
        if (out.bvalid && b_rdy_sel)
          wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      rgnt_q    <= 1'b0;
      wstate_q  <= W_IDLE;
      wgnt_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      rgnt_q    <= rgnt_d;
      wstate_q  <= wstate_d;
      wgnt_q    <= wgnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter; the round-robin section is
// compiled only when AXI_ARB_RR_EN is defined.
module tb_axi_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  axi_if m0 ();
  axi_if m1 ();
  axi_if s ();

  axi_arbiter #(.PRIO_MASTER(1)) dut (
    .clock (clock),
    .reset (reset),
    .in0   (m0),
    .in1   (m1),
    .out   (s)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] rq[$];
  logic [31:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_all();
    m0.arvalid = 0; m0.araddr = 0; m0.arid = 0; m0.arlen = 0;
    m0.arsize = 3'd2; m0.arburst = 2'b01; m0.rready = 0;
    m0.awvalid = 0; m0.awaddr = 0; m0.awid = 0; m0.awlen = 0;
    m0.awsize = 3'd2; m0.awburst = 2'b01;
    m0.wvalid = 0; m0.wdata = 0; m0.wstrb = 0; m0.wlast = 0;
    m0.bready = 0;
    m1.arvalid = 0; m1.araddr = 0; m1.arid = 0; m1.arlen = 0;
    m1.arsize = 3'd2; m1.arburst = 2'b01; m1.rready = 0;
    m1.awvalid = 0; m1.awaddr = 0; m1.awid = 0; m1.awlen = 0;
    m1.awsize = 3'd2; m1.awburst = 2'b01;
    m1.wvalid = 0; m1.wdata = 0; m1.wstrb = 0; m1.wlast = 0;
    m1.bready = 0;
    s.arready = 0; s.rvalid = 0; s.rdata = 0; s.rresp = 0;
    s.rlast = 0; s.rid = 0; s.awready = 0; s.wready = 0;
    s.bvalid = 0; s.bresp = 0; s.bid = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_oarv"}, s.arvalid, 0);
    chk({tag, "_oawv"}, s.awvalid, 0);
    chk({tag, "_owv"}, s.wvalid, 0);
    chk({tag, "_orr"}, s.rready, 0);
    chk({tag, "_obr"}, s.bready, 0);
    chk({tag, "_rdy"}, {m0.arready, m1.arready, m0.awready,
                        m1.awready, m0.wready, m1.wready}, 0);
    chk({tag, "_vld"}, {m0.rvalid, m1.rvalid, m0.bvalid,
                        m1.bvalid}, 0);
  endtask

  // One single-beat read; req0/req1 select requesters, g is the
  // master expected to be granted.
  task automatic read_one(input logic req0, input logic req1,
                          input logic g, input logic [31:0] d);
    logic [31:0] e;
    m0.araddr = 32'h100; m1.araddr = 32'h200;
    m0.arlen = 0; m1.arlen = 0;
    if (req0) m0.arvalid = 1;
    if (req1) m1.arvalid = 1;
    settle();
    tick();
    settle();
    chk("ro_addr", s.araddr, g ? 32'h200 : 32'h100);
    s.arready = 1;
    settle();
    chk("ro_win_rdy", g ? m1.arready : m0.arready, 1);
    chk("ro_lose_rdy", g ? m0.arready : m1.arready, 0);
    tick();
    if (g) m1.arvalid = 0;
    else   m0.arvalid = 0;
    s.arready = 0;
    s.rvalid = 1; s.rdata = d; s.rlast = 1;
    m0.rready = 1; m1.rready = 1;
    rq.push_back(d);
    settle();
    chk("ro_win_rv", g ? m1.rvalid : m0.rvalid, 1);
    chk("ro_lose_rv", g ? m0.rvalid : m1.rvalid, 0);
    e = rq.pop_front();
    chk("ro_rdata", g ? m1.rdata : m0.rdata, e);
    tick();
    s.rvalid = 0; s.rlast = 0;
  endtask

  initial begin
    logic [31:0] e;
    int beats, aw_hs, w_hs, b_hs, early_b;
    logic drop_aw, drop_w;

    clear_all();
    reset = 1;
    tick();
    settle();
    chk_quiet("rst");
    reset = 0;
    tick();
    settle();
    chk_quiet("post_rst");

    // Simultaneous reads: master 1 wins, 4-beat burst with gaps
    m0.araddr = 32'h1000; m0.arid = 4'h2; m0.arlen = 0;
    m1.araddr = 32'h2000; m1.arid = 4'h5; m1.arlen = 3;
    m0.arvalid = 1; m1.arvalid = 1;
    settle();
    chk("t1_idle_arv", s.arvalid, 0);
    tick();
    settle();
    chk("t1_arv", s.arvalid, 1);
    chk("t1_araddr", s.araddr, 32'h2000);
    chk("t1_arlen", s.arlen, 3);
    chk("t1_arid", s.arid, 4'h5);
    s.arready = 1;
    settle();
    chk("t1_m1_ardy", m1.arready, 1);
    chk("t1_m0_ardy", m0.arready, 0);
    tick();
    m1.arvalid = 0; s.arready = 0;
    for (int i = 0; i < 4; i++) rq.push_back(32'hD000_0000 + i);
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      s.rvalid = 1;
      s.rdata = 32'hD000_0000 + beats;
      s.rlast = (beats == 3);
      s.rid = 4'h5;
      m1.rready = ~c[0];
      settle();
      chk("t1_m0_rv", m0.rvalid, 0);
      chk("t1_m0_ardy_hold", m0.arready, 0);
      chk("t1_rready_fwd", s.rready, m1.rready);
      if (m1.rvalid && m1.rready) begin
        if (rq.size() > 0) e = rq.pop_front();
        else e = 32'hDEAD_BEEF;
        chk("t1_rdata", m1.rdata, e);
        chk("t1_rlast", m1.rlast, beats == 3);
        beats++;
      end
      tick();
    end
    s.rvalid = 0; s.rlast = 0;
    chk("t1_beats", beats, 4);
    settle();
    chk("t1_gap_arv", s.arvalid, 0);
    tick();
    settle();
    chk("t1_m0_addr", s.araddr, 32'h1000);
    s.arready = 1;
    settle();
    chk("t1_m0_ardy2", m0.arready, 1);
    tick();
    m0.arvalid = 0; s.arready = 0;
    s.rvalid = 1; s.rdata = 32'h1111; s.rlast = 1; m0.rready = 1;
    settle();
    chk("t1_m0_rv2", m0.rvalid, 1);
    chk("t1_m1_rv2", m1.rvalid, 0);
    chk("t1_m0_rdata", m0.rdata, 32'h1111);
    tick();
    s.rvalid = 0; s.rlast = 0; m0.rready = 0; m1.rready = 0;

    // Concurrent read by master 0 and write by master 1
    m0.araddr = 32'h8000_0000; m0.arvalid = 1;
    m1.awaddr = 32'hA000_0000; m1.awvalid = 1;
    m1.wdata = 32'h1234_5678; m1.wstrb = 4'b0011;
    m1.wlast = 1; m1.wvalid = 1;
    wq.push_back(32'h1234_5678);
    settle();
    tick();
    settle();
    chk("t3_araddr", s.araddr, 32'h8000_0000);
    chk("t3_awaddr", s.awaddr, 32'hA000_0000);
    chk("t3_wstrb", s.wstrb, 4'b0011);
    chk("t3_vlds", {s.arvalid, s.awvalid, s.wvalid}, 3'b111);
    s.arready = 1; s.awready = 1; s.wready = 1;
    settle();
    chk("t3_rdys", {m0.arready, m1.awready, m1.wready}, 3'b111);
    chk("t3_norm", {m1.arready, m0.awready, m0.wready}, 3'b000);
    e = wq.pop_front();
    chk("t3_wdata", s.wdata, e);
    tick();
    m0.arvalid = 0; m1.awvalid = 0; m1.wvalid = 0;
    s.arready = 0; s.awready = 0; s.wready = 0;
    s.rvalid = 1; s.rdata = 32'hCAFE; s.rlast = 1;
    s.bvalid = 1; s.bresp = 2'b10; s.bid = 4'h9;
    m0.rready = 1; m1.bready = 1;
    rq.push_back(32'hCAFE);
    settle();
    chk("t3_m0_rv", m0.rvalid, 1);
    e = rq.pop_front();
    chk("t3_m0_rdata", m0.rdata, e);
    chk("t3_m1_rv", m1.rvalid, 0);
    chk("t3_m1_bv", m1.bvalid, 1);
    chk("t3_m0_bv", m0.bvalid, 0);
    chk("t3_bresp", m1.bresp, 2'b10);
    chk("t3_bid", m1.bid, 4'h9);
    chk("t3_fwd_rdy", {s.rready, s.bready}, 2'b11);
    tick();
    s.rvalid = 0; s.rlast = 0; s.bvalid = 0;
    m0.rready = 0; m1.bready = 0;
    settle();
    chk_quiet("t3_idle");

    // W leads AW by two cycles; slave holds off awready
    m1.awaddr = 32'hB000; m1.awlen = 0;
    m1.wdata = 32'h55; m1.wstrb = 4'hF; m1.wlast = 1;
    m1.wvalid = 1; s.wready = 1;
    s.bvalid = 1; s.bresp = 0; m1.bready = 1;
    wq.push_back(32'h55);
    settle();
    chk("t4_w_idle0", {s.wvalid, m1.wready}, 2'b00);
    tick();
    settle();
    chk("t4_w_idle1", {s.wvalid, m1.wready}, 2'b00);
    tick();
    m1.awvalid = 1;
    settle();
    chk("t4_aw_idle", s.awvalid, 0);
    tick();
    aw_hs = 0; w_hs = 0; b_hs = 0; early_b = 0;
    for (int c = 0; c < 16 && b_hs == 0; c++) begin
      s.awready = (c >= 3);
      settle();
      if ((m1.bvalid || s.bready) && !(aw_hs == 1 && w_hs == 1))
        early_b++;
      drop_aw = m1.awvalid && m1.awready;
      drop_w = m1.wvalid && m1.wready;
      if (s.awvalid && s.awready) aw_hs++;
      if (s.wvalid && s.wready) begin
        w_hs++;
        if (wq.size() > 0) e = wq.pop_front();
        else e = 32'hDEAD_BEEF;
        chk("t4_wdata", s.wdata, e);
      end
      if (m1.bvalid && m1.bready) b_hs++;
      chk("t4_m0_bv", m0.bvalid, 0);
      tick();
      if (drop_aw) m1.awvalid = 0;
      if (drop_w) m1.wvalid = 0;
    end
    s.bvalid = 0; s.awready = 0; s.wready = 0; m1.bready = 0;
    chk("t4_aw_hs", aw_hs, 1);
    chk("t4_w_hs", w_hs, 1);
    chk("t4_b_hs", b_hs, 1);
    chk("t4_early_b", early_b, 0);
    settle();
    chk_quiet("t4_idle");

`ifdef AXI_ARB_RR_EN
    // Lone master 1 read primes last-winner, then ties alternate
    read_one(1'b0, 1'b1, 1'b1, 32'h4000);
    for (int k = 0; k < 4; k++)
      read_one(1'b1, 1'b1, k[0], 32'h5000 + k);
    m0.arvalid = 0; m1.arvalid = 0;
    tick();
`endif

    // Reset during beat 2 of a 4-beat read
    m1.araddr = 32'h3000; m1.arlen = 3; m1.arvalid = 1;
    settle();
    tick();
    s.arready = 1;
    settle();
    chk("t6_ardy", m1.arready, 1);
    tick();
    m1.arvalid = 0; s.arready = 0; m1.rready = 1;
    for (int b = 0; b < 2; b++) begin
      s.rvalid = 1; s.rdata = 32'hE000 + b; s.rlast = 0;
      settle();
      chk("t6_beat", m1.rvalid, 1);
      tick();
    end
    s.rvalid = 1; s.rdata = 32'hE002;
    settle();
    chk("t6_pre_rst", m1.rvalid, 1);
    reset = 1;
    settle();
    chk("t6_orr", s.rready, 0);
    chk("t6_m1_rv", m1.rvalid, 0);
    chk("t6_ardy0", {m0.arready, m1.arready}, 2'b00);
    chk_quiet("t6_rst");
    tick();
    reset = 0;
    clear_all();
    tick();
    settle();
    chk_quiet("t6_idle");
    read_one(1'b1, 1'b0, 1'b0, 32'h7777);
    settle();
    chk_quiet("t6_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
